// File: rtl/rx_frame_parser.sv
// Per-port GMII receive front end.
// Registers the raw byte stream one cycle and tags each registered byte with its frame
// field. Alongside this it captures the destination address, counts the frame length and
// checks CRC-32. One verdict per frame is reported in the single lpCHECK cycle.
//
// Ports:
//   iclk, i_rst        clock, asynchronous active-low reset
//   idv, irx_d, irx_er GMII receive inputs
//   odv, orx_d, orx_er inputs delayed by one cycle
//   oframe_state       field class of the byte currently on orx_d
//   oda, oda_valid     captured destination address (first byte in [47:40])
//   olen               DA..FCS byte count, saturating
//   oframe_done        one-cycle verdict strobe in lpCHECK
//   ogood, oerr_*      verdict, qualified by oframe_done
module rx_frame_parser #(
  parameter int unsigned pDATA_WIDTH        = 8,
  parameter int unsigned pMIN_PACKET_LENGHT = 64,
  parameter int unsigned pMAX_PACKET_LENGHT = 1536,
  parameter int unsigned pLEN_WIDTH         = $clog2(pMAX_PACKET_LENGHT) + 1,
  parameter int unsigned pFSM_BUS_WIDHT     = 4
) (
  input  logic                      iclk,
  input  logic                      i_rst,
  input  logic                      idv,
  input  logic [pDATA_WIDTH-1:0]    irx_d,
  input  logic                      irx_er,
  output logic                      odv,
  output logic [pDATA_WIDTH-1:0]    orx_d,
  output logic                      orx_er,
  output logic [pFSM_BUS_WIDHT-1:0] oframe_state,
  output logic [47:0]               oda,
  output logic                      oda_valid,
  output logic [pLEN_WIDTH-1:0]     olen,
  output logic                      oframe_done,
  output logic                      ogood,
  output logic                      oerr_crc,
  output logic                      oerr_runt,
  output logic                      oerr_long,
  output logic                      oerr_rx
);

  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StPreamble = 4'd1,
    StSfd      = 4'd2,
    StDa       = 4'd3,
    StSa       = 4'd4,
    StLt       = 4'd5,
    StData     = 4'd6,
    StCheck    = 4'd7,
    StDrop     = 4'd8
  } state_e;

  localparam logic [31:0]           CrcResidue = 32'hDEBB20E3;
  localparam logic [pLEN_WIDTH-1:0] MinLen     = pLEN_WIDTH'(pMIN_PACKET_LENGHT);
  localparam logic [pLEN_WIDTH-1:0] MaxLen     = pLEN_WIDTH'(pMAX_PACKET_LENGHT);

  // Reflected CRC-32, one byte, LSB first, no final inversion.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ data[i];
      c  = c >> 1;
      if (fb) c = c ^ 32'hEDB88320;
    end
    return c;
  endfunction

  state_e                  state_q, state_d;
  logic [2:0]              cnt_q, cnt_d;
  logic [31:0]             crc_q, crc_d;
  logic [pLEN_WIDTH-1:0]   len_q, len_d;
  logic [47:0]             da_q, da_d;
  logic                    da_valid_q, da_valid_d;
  logic                    rx_q, rx_d;
  logic                    dv_q;
  logic [pDATA_WIDTH-1:0]  rxd_q;
  logic                    er_q;
  logic                    done_q, good_q, crc_err_q, runt_q, long_q, rx_err_q;

  logic byte_in, sfd_entry, in_frame_d, chk_d;
  logic crc_bad, runt_bad, long_bad;

  // Next field class of the byte being registered this cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle, StPreamble: begin
        if (!idv)                  state_d = StIdle;
        else if (irx_d == 8'h55)   state_d = StPreamble;
        else if (irx_d == 8'hD5)   state_d = StSfd;
        else                       state_d = StDrop;
      end
      StSfd: begin
        if (idv) begin
          state_d = StDa;
          cnt_d   = 3'd0;
        end else begin
          state_d = StIdle;
        end
      end
      StDa: begin
        if (!idv) begin
          state_d = StCheck;
        end else if (cnt_q == 3'd5) begin
          state_d = StSa;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StSa: begin
        if (!idv) begin
          state_d = StCheck;
        end else if (cnt_q == 3'd5) begin
          state_d = StLt;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StLt: begin
        if (!idv) begin
          state_d = StCheck;
        end else if (cnt_q == 3'd1) begin
          state_d = StData;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StData:  state_d = idv ? StData : StCheck;
      StCheck: state_d = StIdle;
      StDrop:  state_d = idv ? StDrop : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Frame datapath, updated with the byte as it is classified.
  always_comb begin
    sfd_entry  = (state_d == StSfd);
    byte_in    = idv && (state_d inside {StDa, StSa, StLt, StData});
    in_frame_d = state_d inside {StSfd, StDa, StSa, StLt, StData};
    chk_d      = (state_d == StCheck);

    crc_d = crc_q;
    if (sfd_entry)    crc_d = 32'hFFFFFFFF;
    else if (byte_in) crc_d = crc_byte(crc_q, irx_d[7:0]);

    len_d = len_q;
    if (sfd_entry)                 len_d = '0;
    else if (byte_in && ~&len_q)   len_d = len_q + 1'b1;

    da_d = da_q;
    if (sfd_entry)                      da_d = '0;
    else if (idv && state_d == StDa)    da_d = {da_q[39:0], irx_d[7:0]};

    da_valid_d = da_valid_q;
    if (state_d == StSa)                                   da_valid_d = 1'b1;
    else if (state_d inside {StCheck, StIdle, StSfd})      da_valid_d = 1'b0;

    rx_d = (sfd_entry ? 1'b0 : rx_q) | (idv && irx_er && in_frame_d);

    // Entering lpCHECK implies idv=0, so crc/len/rx are already final.
    crc_bad  = (crc_q != CrcResidue);
    runt_bad = (len_q < MinLen);
    long_bad = (len_q > MaxLen);
  end

  always_ff @(posedge iclk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      crc_q      <= 32'hFFFFFFFF;
      len_q      <= '0;
      da_q       <= '0;
      da_valid_q <= 1'b0;
      rx_q       <= 1'b0;
      dv_q       <= 1'b0;
      rxd_q      <= '0;
      er_q       <= 1'b0;
      done_q     <= 1'b0;
      good_q     <= 1'b0;
      crc_err_q  <= 1'b0;
      runt_q     <= 1'b0;
      long_q     <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      crc_q      <= crc_d;
      len_q      <= len_d;
      da_q       <= da_d;
      da_valid_q <= da_valid_d;
      rx_q       <= rx_d;
      dv_q       <= idv;
      rxd_q      <= irx_d;
      er_q       <= irx_er;
      done_q     <= chk_d;
      good_q     <= chk_d && !(crc_bad || runt_bad || long_bad || rx_q);
      crc_err_q  <= chk_d && crc_bad;
      runt_q     <= chk_d && runt_bad;
      long_q     <= chk_d && long_bad;
      rx_err_q   <= chk_d && rx_q;
    end
  end

  assign odv          = dv_q;
  assign orx_d        = rxd_q;
  assign orx_er       = er_q;
  assign oframe_state = pFSM_BUS_WIDHT'(state_q);
  assign oda          = da_q;
  assign oda_valid    = da_valid_q;
  assign olen         = len_q;
  assign oframe_done  = done_q;
  assign ogood        = good_q;
  assign oerr_crc     = crc_err_q;
  assign oerr_runt    = runt_q;
  assign oerr_long    = long_q;
  assign oerr_rx      = rx_err_q;

endmodule

// File: doc/rx_frame_parser.md
Name: rx_frame_parser

Overview:
Per-port receive front end of the switch. It sits directly upstream of the packet memory write stage. It registers the raw GMII byte stream and classifies each byte into a frame field, driving the frame-state bus that the memory stage uses to start and stop writing. It also captures the destination address, counts frame length and checks CRC-32, then reports one verdict per frame.

Parameters:
pDATA_WIDTH, 8, GMII data width; only 8 is supported.
pMIN_PACKET_LENGHT, 64, minimum legal frame length, DA through FCS inclusive.
pMAX_PACKET_LENGHT, 1536, maximum legal frame length, DA through FCS inclusive.
pLEN_WIDTH, $clog2(pMAX_PACKET_LENGHT)+1 (=12), width of the length counter.
pFSM_BUS_WIDHT, 4, frame-state bus width. Codes from header.v: lpIDLE=0, lpPREAMBLE=1, lpSFD=2, lpDA=3, lpSA=4, lpLT=5, lpDATA=6, lpCHECK=7, lpDROP=8.

Ports:
iclk  in  1  clock
i_rst  in  1  reset, asynchronous, active-low
idv  in  1  GMII RX_DV
irx_d  in  8  GMII RXD
irx_er  in  1  GMII RX_ER
odv  out  1  idv delayed by 1 cycle
orx_d  out  8  irx_d delayed by 1 cycle
orx_er  out  1  irx_er delayed by 1 cycle
oframe_state  out  pFSM_BUS_WIDHT  field class of the byte currently on orx_d
oda  out  48  captured destination address; first byte received sits in [47:40]
oda_valid  out  1  high from the first lpSA cycle until the next lpCHECK/lpIDLE
olen  out  pLEN_WIDTH  byte count, DA through FCS; saturates at all-ones
oframe_done  out  1  1-cycle pulse in lpCHECK
ogood  out  1  valid with oframe_done: frame accepted
oerr_crc  out  1  valid with oframe_done
oerr_runt  out  1  valid with oframe_done
oerr_long  out  1  valid with oframe_done
oerr_rx  out  1  valid with oframe_done: irx_er was seen inside the frame

Behaviour:
- Reset (i_rst=0, asynchronous): all outputs 0; oframe_state=lpIDLE; CRC register=32'hFFFFFFFF; counters and sticky flags cleared. A reset mid-frame discards the frame with no oframe_done; the parser restarts in lpIDLE.
- Pipeline: the next state is computed combinationally from the current state, idv and irx_d. It is registered in the same cycle as orx_d, so oframe_state always describes orx_d. Latency from input to output is 1 cycle.
- Transitions when idv=1:
  - lpIDLE: 0x55 -> lpPREAMBLE; 0xD5 -> lpSFD; any other byte -> lpDROP.
  - lpPREAMBLE: 0x55 -> stay; 0xD5 -> lpSFD; any other byte -> lpDROP.
  - lpSFD -> lpDA.
  - lpDA: 6 bytes, then lpSA.
  - lpSA: 6 bytes, then lpLT.
  - lpLT: 2 bytes, then lpDATA.
  - lpDATA: stays lpDATA; this covers payload, pad and FCS.
  - lpDROP: stays until idv=0.
  - A 3-bit field counter drives the DA/SA/LT sequencing.
- Transitions when idv=0:
  - From lpDA, lpSA, lpLT or lpDATA -> lpCHECK.
  - From lpIDLE, lpPREAMBLE, lpSFD or lpDROP -> lpIDLE, with no oframe_done.
- lpCHECK lasts exactly 1 cycle, then lpIDLE unconditionally. Input bytes arriving during lpCHECK are ignored; the IFG guarantees none arrive.
- CRC-32, reflected polynomial 0xEDB88320:
  - Register is initialised to 32'hFFFFFFFF on entry to lpSFD.
  - Updated byte-wise, LSB first, for every byte in lpDA through lpDATA.
  - In lpCHECK: oerr_crc = (register != 32'hDEBB20E3).
- olen:
  - Cleared on entry to lpSFD.
  - Incremented once per byte in lpDA through lpDATA.
  - Saturates at 2^pLEN_WIDTH-1.
  - Holds its value through lpCHECK until the next lpSFD.
- Length checks in lpCHECK:
  - oerr_runt = olen < pMIN_PACKET_LENGHT. A frame that ends inside the header is a runt.
  - oerr_long = olen > pMAX_PACKET_LENGHT.
- oerr_rx is a sticky flag: set if irx_er=1 while idv=1 in any state from lpSFD through lpDATA; cleared on the next lpSFD entry. irx_er does not change the state sequence; it is also forwarded on orx_er for the memory stage's abort.
- ogood = !(oerr_crc | oerr_runt | oerr_long | oerr_rx), asserted in lpCHECK only.
- The error flags and ogood are 0 outside lpCHECK.
- oda is shifted in during lpDA, left shift with the new byte in [7:0], and held until the next lpSFD.
- If idv and irx_er are both 1 in lpIDLE, the byte is still classified by value.

Test Plan:
1. Preamble 7x0x55, SFD 0xD5, then a 64-byte frame with DA=01:02:03:04:05:06 and a correct FCS -> oframe_state sequence SFD, DA×6, SA×6, LT×2, DATA×50, then CHECK; olen=64; oda=48'h010203040506; ogood=1 pulse for 1 cycle, 1 cycle after idv falls.
2. Same frame with payload byte 20 XOR 0x01 -> oframe_done=1, oerr_crc=1, ogood=0, olen=64.
3. 60-byte frame with valid CRC -> oerr_runt=1, ogood=0. Frame cut after 3 DA bytes -> CHECK reached, olen=3, oerr_runt=1.
4. 1600-byte frame -> oerr_long=1, olen=1600. Back-to-back 1536-byte frame -> oerr_long=0.
5. Preamble 0x55,0x55,0x5A,... -> lpDROP until idv=0, then lpIDLE, with no oframe_done. The next good frame is accepted with ogood=1.
6. irx_er pulsed on byte 30 of a 64-byte frame -> orx_er high 1 cycle later; oerr_rx=1, ogood=0. Separately, i_rst asserted mid-DATA -> all outputs 0 immediately, no oframe_done, and the next frame parses normally.
